// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a 2-digit multiplexed seven-segment bus: filters, decodes and reassembles frames.
// Optional feature: define SEG_RANGE_CHECK_EN to reject frames whose value exceeds MAX_VALUE.
module seg7_scan_decoder #(
   parameter int unsigned STABLE_CYCLES  = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned MAX_VALUE      = 19
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] led_signal,
   input  logic [1:0] select_led,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic [6:0] value,
   output logic       valid,
   output logic       err,
   output logic       stale
);

   localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef SEG_RANGE_CHECK_EN
   localparam logic RANGE_CHECK = 1'b1;
`else
   localparam logic RANGE_CHECK = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_HAVE_T, S_HAVE_U, S_DONE} state_t;

   state_t        state;
   state_t        base;
   logic [8:0]    samp;
   logic [8:0]    bus;
   logic [SW-1:0] scnt;
   logic [TW-1:0] tcnt;
   logic          cap_fire;
   logic          changed;
   logic          onehot;
   logic          reach;
   logic [3:0]    held_t;
   logic [3:0]    held_u;
   logic [4:0]    dec;
   logic [6:0]    frame_sum;
   logic          in_range;

   // Returns {legal, digit}; a blank tens digit is a legal leading zero.
   function automatic logic [4:0] decode(input logic [6:0] seg, input logic is_tens);
      logic [4:0] r;
      case (seg)
         7'h7E:   r = {1'b1, 4'd0};
         7'h30:   r = {1'b1, 4'd1};
         7'h6D:   r = {1'b1, 4'd2};
         7'h79:   r = {1'b1, 4'd3};
         7'h33:   r = {1'b1, 4'd4};
         7'h5B:   r = {1'b1, 4'd5};
         7'h5F:   r = {1'b1, 4'd6};
         7'h70:   r = {1'b1, 4'd7};
         7'h7F:   r = {1'b1, 4'd8};
         7'h7B:   r = {1'b1, 4'd9};
         7'h00:   r = {is_tens, 4'd0};
         default: r = {1'b0, 4'd0};
      endcase
      return r;
   endfunction

   assign bus       = {select_led, led_signal};
   assign changed   = (bus != samp);
   assign onehot    = ^select_led;
   assign dec       = decode(samp[6:0], samp[8]);
   assign base      = (state == S_DONE) ? S_IDLE : state;
   assign frame_sum = 7'(held_t) * 7'd10 + 7'(held_u);
   assign in_range  = !RANGE_CHECK || (frame_sum <= 7'(MAX_VALUE));
   assign stale     = (tcnt == TW'(TIMEOUT_CYCLES));

   // Fires once per dwell: only on the transition into STABLE_CYCLES.
   always_comb begin
      reach = 1'b0;
      if (changed) reach = (STABLE_CYCLES == 1);
      else         reach = (scnt == SW'(STABLE_CYCLES - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         samp     <= '0;
         scnt     <= '0;
         cap_fire <= 1'b0;
         tcnt     <= '0;
         state    <= S_IDLE;
         held_t   <= '0;
         held_u   <= '0;
         tens     <= '0;
         units    <= '0;
         value    <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
      end else begin
         samp <= bus;
         if (changed)                          scnt <= SW'(1);
         else if (scnt != SW'(STABLE_CYCLES)) scnt <= scnt + SW'(1);
         cap_fire <= onehot && reach;

         if (cap_fire)                          tcnt <= '0;
         else if (tcnt != TW'(TIMEOUT_CYCLES)) tcnt <= tcnt + TW'(1);

         valid <= 1'b0;
         err   <= 1'b0;
         if (state == S_DONE) begin
            if (in_range) begin
               valid <= 1'b1;
               tens  <= held_t;
               units <= held_u;
               value <= frame_sum;
            end else begin
               err <= 1'b1;
            end
         end

         // A capture landing in S_DONE starts a fresh frame from S_IDLE.
         state <= base;
         if (cap_fire) begin
            if (!dec[4]) begin
               err   <= 1'b1;
               state <= S_IDLE;
            end else if (samp[8]) begin
               held_t <= dec[3:0];
               state  <= (base == S_HAVE_U) ? S_DONE : S_HAVE_T;
            end else begin
               held_u <= dec[3:0];
               state  <= (base == S_HAVE_T) ? S_DONE : S_HAVE_U;
            end
         end
      end
   end

endmodule
